// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned display commit.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 50000,
  parameter int BLANK   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            hex,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  upd
);

  // state | meaning
  // IDLE  | scan stopped, all anodes off
  // GAP   | dead time before digit idx, all anodes off
  // SHOW  | digit idx lit for CLK_DIV cycles

  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int MAXC = (CLK_DIV > BLANK) ? CLK_DIV : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [CW-1:0]         cnt;
  logic [4*DIGITS-1:0]   pend_word, disp_word;
  logic [DIGITS-1:0]     pend_dp, disp_dp;
  logic                  blank_now;

  function automatic logic [3:0] nib(input logic [4*DIGITS-1:0] w, input logic [IW-1:0] i);
    return w[4*int'(i) +: 4];
  endfunction

  function automatic logic lz_blank(input logic [4*DIGITS-1:0] w, input logic [IW-1:0] i);
    logic z;
    z = 1'b1;
    for (int k = 0; k < DIGITS; k++)
      if (k >= int'(i) && w[4*k +: 4] != 4'd0) z = 1'b0;
    return z && (i != '0);
  endfunction

  always_comb begin
    blank_now = 1'b0;
`ifdef SEG_LZB_EN
    blank_now = lz_blank(disp_word, idx);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      pend_word <= '0;
      pend_dp   <= '0;
      disp_word <= '0;
      disp_dp   <= '0;
      hex       <= 4'd0;
      an        <= '1;
      dp        <= 1'b0;
      upd       <= 1'b0;
    end else begin
      upd <= 1'b0;
      // Commit below reads the pre-edge pending value, so a coincident load waits a frame.
      if (load) begin
        pend_word <= data;
        pend_dp   <= dp_in;
      end
      if (!en) begin
        state <= IDLE;
        idx   <= '0;
        cnt   <= '0;
        an    <= '1;
        dp    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state     <= GAP;
            idx       <= '0;
            cnt       <= CW'(BLANK - 1);
            disp_word <= pend_word;
            disp_dp   <= pend_dp;
            upd       <= 1'b1;
            hex       <= pend_word[3:0];
            an        <= '1;
            dp        <= 1'b0;
          end
          GAP: begin
            if (cnt == '0) begin
              state <= SHOW;
              cnt   <= CW'(CLK_DIV - 1);
              hex   <= nib(disp_word, idx);
              if (blank_now) begin
                an <= '1;
                dp <= 1'b0;
              end else begin
                an <= ~(DIGITS'(1) << idx);
                dp <= disp_dp[idx];
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          SHOW: begin
            if (cnt == '0) begin
              state <= GAP;
              cnt   <= CW'(BLANK - 1);
              an    <= '1;
              dp    <= 1'b0;
              if (idx == LAST) begin
                idx       <= '0;
                disp_word <= pend_word;
                disp_dp   <= pend_dp;
                upd       <= 1'b1;
                hex       <= pend_word[3:0];
              end else begin
                idx <= idx + IW'(1);
                hex <= nib(disp_word, idx + IW'(1));
              end
            end else begin
              cnt <= cnt - CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: frame-position model checked every cycle plus literal spot checks.
module tb_seg_scan_ctrl;
  localparam int DIGITS = 4;
  localparam int C = 4;
  localparam int B = 2;
  localparam int S = B + C;
  localparam int F = DIGITS * S;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  hex;
  logic [3:0]  an;
  logic        dp;
  logic        upd;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  seg_scan_ctrl #(.DIGITS(DIGITS), .CLK_DIV(C), .BLANK(B)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .dp_in(dp_in),
    .hex(hex), .an(an), .dp(dp), .upd(upd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position in frame since scan start; display word latched at each frame start.
  bit          mrun = 0;
  int          mk = 0;
  logic [15:0] mpend = 0, mdisp = 0;
  logic [3:0]  mpend_dp = 0, mdisp_dp = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mrun = 0; mk = 0; mpend = 0; mdisp = 0; mpend_dp = 0; mdisp_dp = 0;
    end else begin
      if (!en) mrun = 0;
      else begin
        if (!mrun) begin mrun = 1; mk = 0; end
        else mk = (mk + 1) % F;
        if (mk == 0) begin mdisp = mpend; mdisp_dp = mpend_dp; end
      end
      if (load) begin mpend = data; mpend_dp = dp_in; end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic [3:0] e_an, e_hex;
      logic       e_dp, e_upd, lz;
      int d, q;
      d = mk / S;
      q = mk % S;
      e_an = 4'hF; e_dp = 1'b0; e_upd = 1'b0; e_hex = 4'h0;
      if (mrun) begin
        e_hex = mdisp[4*d +: 4];
        e_upd = (mk == 0);
        lz = 1'b0;
`ifdef SEG_LZB_EN
        lz = ((mdisp >> (4*d)) == 16'h0) && (d != 0);
`endif
        if (q >= B && !lz) begin
          e_an = ~(4'b0001 << d);
          e_dp = mdisp_dp[d];
        end
        chk("model_hex", {12'h0, hex}, {12'h0, e_hex});
      end
      chk("model_an", {12'h0, an}, {12'h0, e_an});
      chk("model_dp", {15'h0, dp}, {15'h0, e_dp});
      chk("model_upd", {15'h0, upd}, {15'h0, e_upd});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    #12;
    chk("rst_an", {12'h0, an}, 16'h000F);
    chk("rst_hex", {12'h0, hex}, 16'h0);
    chk("rst_dp", {15'h0, dp}, 16'h0);
    chk("rst_upd", {15'h0, upd}, 16'h0);
    #10 rst_n = 1'b1;
    step();

    // A3F7 with dp on digit 2
    load = 1'b1; data = 16'hA3F7; dp_in = 4'b0100;
    step();
    load = 1'b0; en = 1'b1;
    step(); cyc = 0;
    chk("start_an", {12'h0, an}, 16'h000F);
    chk("start_upd", {15'h0, upd}, 16'h1);
    chk("start_hex", {12'h0, hex}, 16'h0007);
    goto(2);  chk("d0_an", {12'h0, an}, 16'h000E); chk("d0_hex", {12'h0, hex}, 16'h0007);
    goto(8);  chk("d1_an", {12'h0, an}, 16'h000D); chk("d1_hex", {12'h0, hex}, 16'h000F);
    goto(14); chk("d2_an", {12'h0, an}, 16'h000B); chk("d2_hex", {12'h0, hex}, 16'h0003);
    chk("d2_dp", {15'h0, dp}, 16'h1);
    goto(20); chk("d3_an", {12'h0, an}, 16'h0007); chk("d3_hex", {12'h0, hex}, 16'h000A);
    chk("d3_dp", {15'h0, dp}, 16'h0);
    goto(24); chk("frame2_upd", {15'h0, upd}, 16'h1);

    // mid-frame load
    goto(26); load = 1'b1; data = 16'h1234; dp_in = 4'b0000;
    step(); load = 1'b0;
    goto(28); chk("mid_old_d0", {12'h0, hex}, 16'h0007);
    goto(34); chk("mid_old_d1", {12'h0, hex}, 16'h000F);
    goto(48); chk("mid_new_upd", {15'h0, upd}, 16'h1); chk("mid_new_hex", {12'h0, hex}, 16'h0004);

    // load coincident with commit
    goto(71); load = 1'b1; data = 16'h5678; dp_in = 4'b0001;
    step(); load = 1'b0;
    chk("coin_upd", {15'h0, upd}, 16'h1); chk("coin_old_hex", {12'h0, hex}, 16'h0004);
    goto(74); chk("coin_old_dp", {15'h0, dp}, 16'h0);
    goto(96); chk("coin_new_hex", {12'h0, hex}, 16'h0008);
    goto(98); chk("coin_new_dp", {15'h0, dp}, 16'h1); chk("coin_new_an", {12'h0, an}, 16'h000E);

    // en dropped in digit 2 SHOW, then restart
    goto(111); chk("pre_drop_an", {12'h0, an}, 16'h000B);
    en = 1'b0;
    step(); chk("drop_an", {12'h0, an}, 16'h000F); chk("drop_upd", {15'h0, upd}, 16'h0);
    en = 1'b1;
    step(); chk("restart_upd", {15'h0, upd}, 16'h1); chk("restart_hex", {12'h0, hex}, 16'h0008);
    goto(115); chk("restart_an", {12'h0, an}, 16'h000E);

    // async reset mid-SHOW
    goto(116);
    rst_n = 1'b0;
    #1;
    chk("arst_an", {12'h0, an}, 16'h000F);
    chk("arst_hex", {12'h0, hex}, 16'h0);
    chk("arst_upd", {15'h0, upd}, 16'h0);
    #1 rst_n = 1'b1;
    step();
    chk("post_rst_upd", {15'h0, upd}, 16'h1);

    // leading zeros
    en = 1'b0;
    step();
    load = 1'b1; data = 16'h0050; dp_in = 4'b1111;
    step();
    load = 1'b0; en = 1'b1;
    step(); cyc = 0;
    goto(2); chk("lz_d0_an", {12'h0, an}, 16'h000E); chk("lz_d0_hex", {12'h0, hex}, 16'h0);
    goto(8); chk("lz_d1_an", {12'h0, an}, 16'h000D); chk("lz_d1_hex", {12'h0, hex}, 16'h0005);
    goto(14);
`ifdef SEG_LZB_EN
    chk("lz_d2_an", {12'h0, an}, 16'h000F); chk("lz_d2_dp", {15'h0, dp}, 16'h0);
`else
    chk("lz_d2_an", {12'h0, an}, 16'h000B); chk("lz_d2_dp", {15'h0, dp}, 16'h1);
`endif
    goto(20);
`ifdef SEG_LZB_EN
    chk("lz_d3_an", {12'h0, an}, 16'h000F);
`else
    chk("lz_d3_an", {12'h0, an}, 16'h0007);
`endif
    goto(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
